// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and defaults for the fetch stage and its IF/ID register.
package pipeline_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT,
    HELD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN_DEF-1:0] pc4;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load, otherwise it holds.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [31:0]      NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc4_in,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Select between bubble, a new fetched word, or holding the current contents.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_WORD;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  // Register the stage contents; reset leaves a bubble in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC, req/ready imem port, one-entry
// stall buffer and branch redirect handling (also while a request is in flight).
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush/redirect counters.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}},
  parameter logic [31:0]      NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            holdPC,
  input  logic            IF_ID_Flush,
  input  logic            isBranch,
  input  logic [XLEN-1:0] PC_offset,
  input  logic [XLEN-1:0] PC4_ID_EX,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_IF_ID,
  output logic [XLEN-1:0] PC4_IF_ID,
  output logic            valid_IF_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     redirect_cnt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            kill_q, kill_d;
  logic [31:0]     buf_q, buf_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] branch_target;

  logic            ifid_load;
  logic            ifid_bubble;
  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc4;

  assign pc_plus4      = pc_q + XLEN'(4);
  assign target_sum    = PC4_ID_EX + (PC_offset << 2);
  assign branch_target = {target_sum[XLEN-1:2], 2'b00};

  // State register plus PC, pending redirect, kill flag and stall buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
      kill_q     <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      kill_q     <= kill_d;
      buf_q      <= buf_d;
    end
  end

  // Next-state: a branch always returns to FETCH (or waits out a live request).
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:     state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          if (!isBranch && holdPC) state_d = HELD;
        end else if (isBranch) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: if (imem_ready) state_d = FETCH;
      HELD:     if (isBranch || !holdPC) state_d = FETCH;
      default:  state_d = BOOT;
    endcase
  end

  // Outputs and datapath updates: memory request, PC, buffer and IF/ID controls.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    pc_d        = pc_q;
    redirect_d  = redirect_q;
    kill_d      = kill_q;
    buf_d       = buf_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata;
    ifid_pc4    = pc_plus4;
    case (state_q)
      BOOT: ifid_bubble = 1'b1;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (isBranch) begin
            pc_d        = branch_target;
            ifid_bubble = 1'b1;
          end else if (holdPC) begin
            buf_d       = imem_rdata;
            ifid_bubble = IF_ID_Flush;
          end else if (IF_ID_Flush) begin
            ifid_bubble = 1'b1;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end
        end else if (isBranch) begin
          kill_d      = 1'b1;
          redirect_d  = branch_target;
          ifid_bubble = 1'b1;
        end else begin
          ifid_bubble = !holdPC || IF_ID_Flush;
        end
      end
      REDIRECT: begin
        imem_req    = 1'b1;
        ifid_bubble = 1'b1;
        if (isBranch) redirect_d = branch_target;
        if (imem_ready && kill_q) begin
          pc_d   = isBranch ? branch_target : redirect_q;
          kill_d = 1'b0;
        end
      end
      HELD: begin
        if (isBranch) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
        end else if (holdPC) begin
          ifid_bubble = IF_ID_Flush;
        end else begin
          ifid_load  = 1'b1;
          ifid_instr = buf_q;
          pc_d       = pc_plus4;
        end
      end
      default: ifid_bubble = 1'b1;
    endcase
  end

  if_id_reg #(
    .XLEN     (XLEN),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (ifid_instr),
    .pc4_in   (ifid_pc4),
    .instr    (instr_IF_ID),
    .pc4      (PC4_IF_ID),
    .valid    (valid_IF_ID)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  // Saturating increments for stall cycles, inserted bubbles and taken branches.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (holdPC && (stall_cnt_q != '1))         stall_cnt_d    = stall_cnt_q + 32'd1;
    if (ifid_bubble && (flush_cnt_q != '1))    flush_cnt_d    = flush_cnt_q + 32'd1;
    if (isBranch && (redirect_cnt_q != '1))    redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule
